// File: rtl/stack_ctrl_if.sv
// Requester, response and stack-side signals of the stack controller.
// The controller takes the slave view; requesters and the stack take the master view.
interface stack_ctrl_if;
    logic       req0;
    logic [2:0] cmd0;
    logic [7:0] data0;
    logic       gnt0;
    logic       req1;
    logic [2:0] cmd1;
    logic [7:0] data1;
    logic       gnt1;

    logic       done;
    logic       done_id;
    logic       err;
    logic [7:0] result;
    logic       busy;

    logic       stk_rst;
    logic       stk_en;
    logic       stk_op;
    logic       stk_op_en;
    logic [7:0] stk_din;
    logic [7:0] stk_top;
    logic [7:0] stk_top_mo;
    logic       stk_ovf;
    logic       stk_unf;

    modport slave (
        input  req0, cmd0, data0, req1, cmd1, data1,
        input  stk_top, stk_top_mo, stk_ovf, stk_unf,
        output gnt0, gnt1, done, done_id, err, result, busy,
        output stk_rst, stk_en, stk_op, stk_op_en, stk_din
    );

    modport master (
        output req0, cmd0, data0, req1, cmd1, data1,
        output stk_top, stk_top_mo, stk_ovf, stk_unf,
        input  gnt0, gnt1, done, done_id, err, result, busy,
        input  stk_rst, stk_en, stk_op, stk_op_en, stk_din
    );
endinterface

// File: rtl/stack_ctrl.sv
// Two-requester round-robin controller that turns stack commands into
// back-to-back push/pop cycles on an external stack and reports one response each.
module stack_ctrl (
    input  logic         clk,
    input  logic         reset,
    stack_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, RESP = 2'd2} state_t;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_PUSH = 3'd1;
    localparam logic [2:0] OP_POP  = 3'd2;
    localparam logic [2:0] OP_DUP  = 3'd3;
    localparam logic [2:0] OP_SWAP = 3'd4;
    localparam logic [2:0] OP_ADD  = 3'd5;

    state_t     stateReg, stateNext;
    logic [5:0] depthReg;
    logic       lastGntReg;
    logic       idReg;
    logic [2:0] cmdReg;
    logic [7:0] dataReg, aReg, bReg;
    logic [1:0] stepReg;
    logic       errReg;

    logic       winId, accept, acceptErr, skipRun, stackCycle;
    logic [2:0] winCmd;
    logic [7:0] winData, sumVal, seqDin, resultVal;
    logic       seqOp, lastStep;

    // On a tie the requester that was not granted last wins.
    always_comb begin
        if (bus.req0 && bus.req1) winId = ~lastGntReg;
        else                      winId = bus.req1;
    end

    assign accept     = (stateReg == IDLE) && (bus.req0 || bus.req1) && !reset;
    assign winCmd     = winId ? bus.cmd1  : bus.cmd0;
    assign winData    = winId ? bus.data1 : bus.data0;
    assign stackCycle = (stateReg == RUN) && !reset;
    assign sumVal     = aReg + bReg;
    assign skipRun    = acceptErr || (winCmd == OP_NOP);

    always_comb begin
        acceptErr = 1'b0;
        case (winCmd)
            OP_NOP:          acceptErr = 1'b0;
            OP_PUSH:         acceptErr = (depthReg == 6'd32);
            OP_POP:          acceptErr = (depthReg == 6'd0);
            OP_DUP:          acceptErr = (depthReg == 6'd0) || (depthReg == 6'd32);
            OP_SWAP, OP_ADD: acceptErr = (depthReg < 6'd2);
            default:         acceptErr = 1'b1;
        endcase
    end

    // Per-step stack operation for the latched command.
    always_comb begin
        seqOp    = 1'b0;
        seqDin   = 8'd0;
        lastStep = 1'b1;
        case (cmdReg)
            OP_PUSH: begin seqOp = 1'b1; seqDin = dataReg; end
            OP_DUP:  begin seqOp = 1'b1; seqDin = aReg; end
            OP_SWAP: begin
                lastStep = (stepReg == 2'd3);
                if (stepReg == 2'd2)      begin seqOp = 1'b1; seqDin = aReg; end
                else if (stepReg == 2'd3) begin seqOp = 1'b1; seqDin = bReg; end
            end
            OP_ADD: begin
                lastStep = (stepReg == 2'd2);
                if (stepReg == 2'd2) begin seqOp = 1'b1; seqDin = sumVal; end
            end
            default: ;
        endcase
    end

    always_comb begin
        resultVal = 8'd0;
        case (cmdReg)
            OP_PUSH:        resultVal = dataReg;
            OP_POP, OP_DUP: resultVal = aReg;
            OP_SWAP:        resultVal = bReg;
            OP_ADD:         resultVal = sumVal;
            default:        resultVal = 8'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) stateReg <= IDLE;
        else       stateReg <= stateNext;
    end

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE:    if (accept) stateNext = skipRun ? RESP : RUN;
            RUN:     if (lastStep) stateNext = RESP;
            RESP:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            depthReg   <= 6'd0;
            lastGntReg <= 1'b1;
            idReg      <= 1'b0;
            cmdReg     <= OP_NOP;
            dataReg    <= 8'd0;
            aReg       <= 8'd0;
            bReg       <= 8'd0;
            stepReg    <= 2'd0;
            errReg     <= 1'b0;
        end else begin
            if (accept) begin
                lastGntReg <= winId;
                idReg      <= winId;
                cmdReg     <= winCmd;
                dataReg    <= winData;
                aReg       <= bus.stk_top;
                bReg       <= bus.stk_top_mo;
                stepReg    <= 2'd0;
                errReg     <= acceptErr;
            end
            if (stackCycle) begin
                stepReg <= stepReg + 2'd1;
                if (seqOp && depthReg != 6'd32)      depthReg <= depthReg + 6'd1;
                else if (!seqOp && depthReg != 6'd0) depthReg <= depthReg - 6'd1;
                // Stack flags disagreeing with our depth model turn into an error response.
                if (bus.stk_ovf || bus.stk_unf) errReg <= 1'b1;
            end
        end
    end

    always_comb begin
        bus.gnt0      = accept && !winId;
        bus.gnt1      = accept && winId;
        bus.busy      = (stateReg != IDLE);
        bus.done      = 1'b0;
        bus.done_id   = 1'b0;
        bus.err       = 1'b0;
        bus.result    = 8'd0;
        // The stack's own reset only takes effect while it is enabled.
        bus.stk_rst   = reset;
        bus.stk_en    = reset || stackCycle;
        bus.stk_op_en = stackCycle;
        bus.stk_op    = stackCycle && seqOp;
        bus.stk_din   = stackCycle ? seqDin : 8'd0;
        if (stateReg == RESP) begin
            bus.done    = 1'b1;
            bus.done_id = idReg;
            bus.err     = errReg;
            bus.result  = errReg ? 8'd0 : resultVal;
        end
    end
endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: behavioural stack, vector table, scoreboard of expected
// responses, plus hand sequences for full stack, flag errors, arbitration and reset.
module tb_stack_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    stack_ctrl_if bus();
    stack_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

    localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, DUP = 3'd3, SWAP = 3'd4, ADD = 3'd5;

    // Behavioural stack driven by the controller's stack-side outputs.
    logic [7:0] stkMem [0:31];
    logic [5:0] sp = 6'd0;
    logic [5:0] spm1, spm2;
    logic       forceUnf = 1'b0;
    assign spm1 = sp - 6'd1;
    assign spm2 = sp - 6'd2;
    always @(posedge clk) begin
        if (bus.stk_en && bus.stk_rst) sp <= 6'd0;
        else if (bus.stk_en && bus.stk_op_en) begin
            if (bus.stk_op) begin
                if (sp < 6'd32) begin stkMem[sp[4:0]] <= bus.stk_din; sp <= sp + 6'd1; end
            end else if (sp > 6'd0) sp <= sp - 6'd1;
        end
    end
    assign bus.stk_top    = (sp >= 6'd1) ? stkMem[spm1[4:0]] : 8'h00;
    assign bus.stk_top_mo = (sp >= 6'd2) ? stkMem[spm2[4:0]] : 8'h00;
    assign bus.stk_ovf    = 1'b0;
    assign bus.stk_unf    = forceUnf;

    typedef struct { logic id; logic [2:0] cmd; logic err; logic [7:0] result; int gntCycle; int nStk; } exp_t;
    typedef struct { logic id; logic [2:0] cmd; logic [7:0] data; logic expErr; logic [7:0] expRes; int nStk; int expDepth; } vec_t;

    exp_t sbq[$];
    int checks = 0, errors = 0, cycle = 0, stkCount = 0, doneCount = 0;

    always @(posedge clk) begin
        cycle <= cycle + 1;
        if (bus.stk_en && bus.stk_op_en) stkCount <= stkCount + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Response monitor: every done pops one expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.done) begin
                if (sbq.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    $display("txn id=%0d cmd=%0d err=%0d result=%02h latency=%0d",
                             bus.done_id, e.cmd, bus.err, bus.result, cycle - e.gntCycle);
                    check("done_id", bus.done_id, e.id);
                    check("err", bus.err, e.err);
                    check("result", bus.result, e.result);
                    check("latency", cycle - e.gntCycle, e.nStk + 1);
                end
                doneCount++;
            end
        end
    end

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1; bus.req0 = 1'b0; bus.req1 = 1'b0;
        @(negedge clk); #1;
        check("rst_stk_rst", bus.stk_rst, 1);
        check("rst_stk_en", bus.stk_en, 1);
        check("rst_stk_op_en", bus.stk_op_en, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_depth", dut.depthReg, 0);
        @(negedge clk);
        reset = 1'b0;
        sbq.delete();
        #1;
        check("post_rst_stk_en", bus.stk_en, 0);
    endtask

    task automatic doCmd(input logic id, input logic [2:0] cmd, input logic [7:0] data,
                         input logic expErr, input logic [7:0] expRes, input int nStk);
        int startStk, startDone;
        bit got, fin;
        exp_t e;
        got = 0; fin = 0;
        @(negedge clk);
        if (id) begin bus.req1 = 1'b1; bus.cmd1 = cmd; bus.data1 = data; end
        else    begin bus.req0 = 1'b1; bus.cmd0 = cmd; bus.data0 = data; end
        for (int i = 0; i < 20; i++) begin
            #1;
            if (id ? bus.gnt1 : bus.gnt0) begin got = 1; break; end
            @(negedge clk);
        end
        if (!got) begin
            check("gnt_timeout", 0, 1);
            bus.req0 = 1'b0; bus.req1 = 1'b0;
            return;
        end
        check("gnt_other", id ? bus.gnt0 : bus.gnt1, 0);
        startStk = stkCount; startDone = doneCount;
        e.id = id; e.cmd = cmd; e.err = expErr; e.result = expRes; e.gntCycle = cycle; e.nStk = nStk;
        sbq.push_back(e);
        @(negedge clk);
        if (id) bus.req1 = 1'b0; else bus.req0 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #2;
            if (doneCount > startDone) begin fin = 1; break; end
            @(negedge clk);
        end
        check("done_seen", fin, 1);
        check("stk_cycles", stkCount - startStk, nStk);
    endtask

    vec_t vecs[14];

    initial begin
        int g;
        logic who;
        exp_t e;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.cmd0 = 3'd0; bus.cmd1 = 3'd0; bus.data0 = 8'd0; bus.data1 = 8'd0;

        vecs[0]  = '{1'b0, PUSH, 8'h12, 1'b0, 8'h12, 1, 1};
        vecs[1]  = '{1'b0, PUSH, 8'h34, 1'b0, 8'h34, 1, 2};
        vecs[2]  = '{1'b1, ADD,  8'h00, 1'b0, 8'h46, 3, 1};
        vecs[3]  = '{1'b0, NOP,  8'h00, 1'b0, 8'h00, 0, 1};
        vecs[4]  = '{1'b1, POP,  8'h00, 1'b0, 8'h46, 1, 0};
        vecs[5]  = '{1'b0, POP,  8'h00, 1'b1, 8'h00, 0, 0};
        vecs[6]  = '{1'b1, PUSH, 8'h20, 1'b0, 8'h20, 1, 1};
        vecs[7]  = '{1'b0, PUSH, 8'hF0, 1'b0, 8'hF0, 1, 2};
        vecs[8]  = '{1'b0, SWAP, 8'h00, 1'b0, 8'h20, 4, 2};
        vecs[9]  = '{1'b1, ADD,  8'h00, 1'b0, 8'h10, 3, 1};
        vecs[10] = '{1'b1, DUP,  8'h00, 1'b0, 8'h10, 1, 2};
        vecs[11] = '{1'b0, 3'd6, 8'h00, 1'b1, 8'h00, 0, 2};
        vecs[12] = '{1'b1, 3'd7, 8'h00, 1'b1, 8'h00, 0, 2};
        vecs[13] = '{1'b0, SWAP, 8'h00, 1'b0, 8'h10, 4, 2};

        doReset();
        for (int i = 0; i < 14; i++) begin
            doCmd(vecs[i].id, vecs[i].cmd, vecs[i].data, vecs[i].expErr, vecs[i].expRes, vecs[i].nStk);
            check("depth", dut.depthReg, vecs[i].expDepth);
        end

        // Fill to 32, then PUSH and DUP must be rejected.
        doReset();
        for (int i = 0; i < 32; i++) doCmd(i[0], PUSH, 8'(i + 1), 1'b0, 8'(i + 1), 1);
        doCmd(1'b0, PUSH, 8'hEE, 1'b1, 8'h00, 0);
        check("full_depth", dut.depthReg, 32);
        doCmd(1'b1, DUP, 8'h00, 1'b1, 8'h00, 0);
        check("full_top", bus.stk_top, 8'd32);

        // Stack flag during RUN: sequence completes, response errors.
        doReset();
        forceUnf = 1'b1;
        doCmd(1'b0, PUSH, 8'h55, 1'b1, 8'h00, 1);
        forceUnf = 1'b0;

        // Both requesters held high: grants must alternate starting with req0.
        doReset();
        @(negedge clk);
        bus.req0 = 1'b1; bus.cmd0 = PUSH; bus.data0 = 8'hA0;
        bus.req1 = 1'b1; bus.cmd1 = PUSH; bus.data1 = 8'hB0;
        g = 0;
        for (int i = 0; i < 60 && g < 4; i++) begin
            #1;
            if (bus.gnt0 || bus.gnt1) begin
                who = bus.gnt1;
                check("rr_order", who, g % 2);
                check("rr_single", bus.gnt0 && bus.gnt1, 0);
                e.id = who; e.cmd = PUSH; e.err = 1'b0; e.result = who ? bus.data1 : bus.data0;
                e.gntCycle = cycle; e.nStk = 1;
                sbq.push_back(e);
                g++;
                @(negedge clk);
                if (who) bus.data1 = bus.data1 + 8'd1; else bus.data0 = bus.data0 + 8'd1;
            end else begin
                @(negedge clk);
            end
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        check("rr_grants", g, 4);
        for (int i = 0; i < 20; i++) begin
            if (sbq.size() == 0) break;
            @(negedge clk);
        end
        check("rr_all_done", sbq.size(), 0);
        check("rr_depth", dut.depthReg, 4);

        // Reset in the middle of a SWAP.
        doReset();
        doCmd(1'b0, PUSH, 8'h01, 1'b0, 8'h01, 1);
        doCmd(1'b0, PUSH, 8'h02, 1'b0, 8'h02, 1);
        @(negedge clk);
        bus.req0 = 1'b1; bus.cmd0 = SWAP;
        #1;
        check("swap_gnt", bus.gnt0, 1);
        @(negedge clk);
        bus.req0 = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rst_stk_rst", bus.stk_rst, 1);
        check("mid_rst_stk_en", bus.stk_en, 1);
        check("mid_rst_op_en", bus.stk_op_en, 0);
        @(negedge clk); #1;
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_done", bus.done, 0);
        check("mid_rst_depth", dut.depthReg, 0);
        check("mid_rst_stk_en2", bus.stk_en, 1);
        reset = 1'b0;
        doCmd(1'b0, PUSH, 8'h77, 1'b0, 8'h77, 1);
        check("after_rst_depth", dut.depthReg, 1);
        check("after_rst_top", bus.stk_top, 8'h77);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
